// File: rtl/aes_round_ctrl.sv
// Sequencing controller for an iterative AES-128 encryption datapath.
// One block per in handshake; NR+1 load cycles, then result held until out_ready.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       state_load,
  output logic [1:0] state_sel,
  output logic       key_load,
  output logic       key_sel,
  output logic [3:0] round,
  output logic [7:0] rcon,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [3:0] NR_L  = 4'(NR);
  localparam logic [3:0] NR_M1 = 4'(NR - 1);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [7:0] rcon_q, rcon_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      rcon_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    rcon_d     = rcon_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    state_load = 1'b0;
    state_sel  = 2'd0;
    key_load   = 1'b0;
    key_sel    = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        round_d  = 4'd0;
        rcon_d   = 8'd0;
        if (in_valid) begin
          state_load = 1'b1;
          key_load   = 1'b1;
          round_d    = 4'd1;
          rcon_d     = 8'h01;
          state_d    = (NR > 1) ? ROUND : FINAL;
        end
      end
      ROUND: begin
        state_load = 1'b1;
        state_sel  = 2'd1;
        key_load   = 1'b1;
        key_sel    = 1'b1;
        busy       = 1'b1;
        round_d    = round_q + 4'd1;
        rcon_d     = xtime(rcon_q);
        if (round_q == NR_M1) state_d = FINAL;
      end
      FINAL: begin
        state_load = 1'b1;
        state_sel  = 2'd2;
        key_load   = 1'b1;
        key_sel    = 1'b1;
        busy       = 1'b1;
        round_d    = NR_L;
        rcon_d     = 8'd0;
        state_d    = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        round_d   = NR_L;
        rcon_d    = 8'd0;
        if (out_ready) begin
          state_d = IDLE;
          round_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset wins combinationally: no loads or handshakes in a reset cycle.
    if (rst) begin
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      state_load = 1'b0;
      state_sel  = 2'd0;
      key_load   = 1'b0;
      key_sel    = 1'b0;
      busy       = 1'b0;
    end
  end

  assign round = round_q;
  assign rcon  = rcon_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench: three controllers (NR=10, 2, 14) share random stimulus and are compared
// every cycle against a cycles-since-accept reference model.
module tb_aes_round_ctrl;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic out_ready;

  logic       in_ready   [NI];
  logic       out_valid  [NI];
  logic       state_load [NI];
  logic [1:0] state_sel  [NI];
  logic       key_load   [NI];
  logic       key_sel    [NI];
  logic [3:0] round      [NI];
  logic [7:0] rcon       [NI];
  logic       busy       [NI];

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(10)) u_nr10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .state_load(state_load[0]),
    .state_sel(state_sel[0]), .key_load(key_load[0]), .key_sel(key_sel[0]),
    .round(round[0]), .rcon(rcon[0]), .busy(busy[0]));

  aes_round_ctrl #(.NR(2)) u_nr2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .state_load(state_load[1]),
    .state_sel(state_sel[1]), .key_load(key_load[1]), .key_sel(key_sel[1]),
    .round(round[1]), .rcon(rcon[1]), .busy(busy[1]));

  aes_round_ctrl #(.NR(14)) u_nr14 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready), .state_load(state_load[2]),
    .state_sel(state_sel[2]), .key_load(key_load[2]), .key_sel(key_sel[2]),
    .round(round[2]), .rcon(rcon[2]), .busy(busy[2]));

  int vectors = 0;
  int errors  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 0 = idle, 1 = working (k cycles since accept), 2 = result held.
  int nr   [NI] = '{10, 2, 14};
  int mode [NI] = '{0, 0, 0};
  int k    [NI] = '{0, 0, 0};
  int ohs  [NI] = '{0, 0, 0};
  int rc   [16];

  initial begin
    rc[0] = 0;
    rc[1] = 1;
    for (int r = 2; r < 16; r++)
      rc[r] = (rc[r-1] * 2) ^ ((rc[r-1] >= 128) ? 'h11B : 0);
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic ir, ov, sl, kl, ks, bz;
      logic [1:0] ss;
      logic [3:0] rd;
      logic [7:0] rcv;
      logic [19:0] e_vec, o_vec;
      string tag;
      {ir, ov, sl, kl, ks, bz, ss, rd, rcv} = '0;
      if (!rst) begin
        if (mode[i] == 0) begin
          ir = 1'b1;
          if (in_valid) begin sl = 1'b1; kl = 1'b1; end
        end else if (mode[i] == 1) begin
          sl = 1'b1; kl = 1'b1; ks = 1'b1; bz = 1'b1;
          ss  = (k[i] < nr[i]) ? 2'd1 : 2'd2;
          rd  = 4'(k[i]);
          rcv = 8'(rc[k[i]]);
        end else begin
          ov = 1'b1; bz = 1'b1;
          rd = 4'(nr[i]);
        end
      end
      e_vec = {ir, ov, sl, ss, kl, ks, bz, rd, rcv};
      o_vec = {in_ready[i], out_valid[i], state_load[i], state_sel[i], key_load[i],
               key_sel[i], busy[i], round[i], rcon[i]};
      // round/rcon are registered and may lag one cycle under reset
      if (rst) o_vec[11:0] = '0;
      tag = $sformatf("nr%0d_outputs", nr[i]);
      check_eq(tag, {12'd0, o_vec}, {12'd0, e_vec});

      if (rst) begin
        mode[i] = 0;
      end else if (mode[i] == 0) begin
        if (in_valid) begin mode[i] = 1; k[i] = 1; end
      end else if (mode[i] == 1) begin
        if (k[i] == nr[i]) mode[i] = 2;
        else k[i] = k[i] + 1;
      end else if (out_ready) begin
        mode[i] = 0;
        ohs[i]++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
    // single block, out_ready tied high
    in_valid = 1'b1; step(1); in_valid = 1'b0;
    step(17);
    // backpressure with ignored in_valid
    in_valid = 1'b1; step(1);
    out_ready = 1'b0; step(20);
    out_ready = 1'b1; in_valid = 1'b0; step(3);
    // back-to-back
    in_valid = 1'b1; out_ready = 1'b1; step(60);
    in_valid = 1'b0; step(16);
    // reset in the middle of a block, then a normal block
    in_valid = 1'b1; step(1); in_valid = 1'b0;
    step(4);
    rst = 1'b1; step(1); rst = 1'b0;
    in_valid = 1'b1; step(1); in_valid = 1'b0;
    step(16);
    // reset while result is held
    out_ready = 1'b0; in_valid = 1'b1; step(1); in_valid = 1'b0;
    step(14);
    rst = 1'b1; step(1); rst = 1'b0; out_ready = 1'b1;
    step(3);
    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 149) == 0);
      step(1);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(20);
    for (int i = 0; i < NI; i++)
      check_eq($sformatf("nr%0d_results_seen", nr[i]), 32'(ohs[i] > 5), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencing controller for the iterative 128-bit AES encryption datapath. It accepts one plaintext/key block per valid/ready handshake and drives the load enables and mux selects of the 128-bit state and round-key registers. It issues the round number and round constant for each of the NR rounds, then holds the result with a valid/ready output handshake. The block contains control only: the datapath, S-box, MixColumns and key-expansion logic sit outside it.

## Interface
- NR, 10, number of AES rounds; legal range 2..15
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  plaintext and cipher key are present on the datapath inputs
- in_ready  out  1  controller can accept a block
- out_valid  out  1  ciphertext in the state register is final
- out_ready  in  1  consumer takes the ciphertext
- state_load  out  1  load enable of the state register
- state_sel  out  2  state mux select: 0 = plaintext XOR key, 1 = full round, 2 = final round (no MixColumns), 3 = unused
- key_load  out  1  load enable of the round-key register
- key_sel  out  1  key mux select: 0 = cipher key, 1 = expanded next key
- round  out  4  current round number
- rcon  out  8  round constant for the current round's key expansion
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ROUND, FINAL, DONE. Encoding is free.
- Datapath contract for round r: next_key = expand(key_q, rcon) and state_d = round(state_q, next_key), both combinational. The state and key registers load in the same cycle.
- IDLE:
  - in_ready=1, round=0, rcon=0.
  - On in_valid: state_load=1, state_sel=0, key_load=1, key_sel=0 (Mealy, same cycle). round is set to 1 and rcon to 0x01.
  - Next state: ROUND if NR>1, otherwise FINAL.
- ROUND:
  - state_load=1, state_sel=1, key_load=1, key_sel=1.
  - round increments each cycle. rcon advances by xtime: rcon<<1, XOR 0x1B when bit 7 was set.
  - When round==NR-1, the next state is FINAL.
- FINAL (round==NR):
  - state_load=1, state_sel=2, key_load=1, key_sel=1.
  - Next state is DONE. round stays NR.
- DONE:
  - out_valid=1, no loads, round=NR, rcon=0.
  - The result is held for as many cycles as out_ready stays low.
  - On out_ready=1: next state IDLE, round is cleared to 0.
- in_ready=0 in ROUND, FINAL and DONE. in_valid in those states is ignored and not queued.
- out_valid and in_ready are never high in the same cycle.
- rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36. For NR>10 the xtime progression continues: 6C,D8,AB,4D,9A.
- state_sel, key_sel, round and rcon are 0 whenever the corresponding load is low. The exception is round in DONE, which shows NR.

## Timing
- Reset values, held while rst=1 and on the first cycle after release:
  - state IDLE, round=0, rcon=0.
  - out_valid=0, state_load=0, key_load=0, busy=0.
  - in_ready=0 while rst=1. in_ready=1 from the first cycle rst is low.
- rst has priority over every other input.
  - An assertion mid-encryption (ROUND, FINAL or DONE) returns the controller to IDLE on the next edge.
  - No loads are issued in the reset cycle.
  - The pending result is discarded and out_valid drops.
- Latency: the accept cycle is t0. ROUND occupies t1..t(NR-1), FINAL is at tNR, and out_valid=1 from t(NR+1).
  - With NR=10, out_valid rises 11 cycles after the accept edge.
- Throughput: at most one block per NR+2 cycles.
  - That minimum needs out_ready=1 during the first DONE cycle and in_valid=1 in the following IDLE cycle.
- An in_valid/out_ready handshake only completes in the state that owns it (IDLE for input, DONE for output).
- round and rcon are registered. They change only on a clock edge.

## Test plan
- Reset then single block, NR=10, out_ready tied 1:
  - in_ready=1 at the first cycle after reset.
  - in_valid pulse gives state_sel=0 loads at t0.
  - state_sel=1 with round=1..9 and rcon 01..1B at t1..t9.
  - state_sel=2 with round=10 and rcon=36 at t10.
  - out_valid=1 for exactly one cycle at t11.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_valid stays 1 and no loads occur.
  - in_ready stays 0 while in_valid=1 is ignored.
  - Release out_ready: IDLE on the next cycle.
- Back-to-back blocks with in_valid=1 and out_ready=1 constantly:
  - Accepts occur every 12 cycles.
  - Each block's load sequence is identical.
- Reset mid-operation: assert rst at round=5 for one cycle.
  - No load on the reset cycle, and the next cycle is IDLE with round=0 and out_valid=0.
  - A following block completes normally.
- Reset asserted in DONE with out_valid=1: out_valid=0 on the next cycle, and the held result is never acknowledged.
- Parameter sweep NR=2 and NR=14:
  - NR=2: one ROUND cycle (round=1), FINAL with rcon=02, out_valid 3 cycles after accept.
  - NR=14: rcon=4D at round 14.
